// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and
//   load/store (DM). It registers one request at a time, runs a req/gnt +
//   rvalid handshake to the memory, and returns the response to whichever
//   requester won. DM has priority. A starvation counter forces an IF win
//   after STARVE_LIMIT consecutive DM wins while IF is waiting.
//
//   Ports
//     i_clk, i_reset        clock, asynchronous active-high reset
//     i_if_req/i_if_addr    fetch request (level) and address
//     o_if_rdata/o_if_valid fetched word and one-cycle completion pulse
//     o_if_stall            fetch stall to hazard logic
//     i_dm_req/we/addr/wdata/wstrb   load/store request and payload
//     o_dm_rdata/o_dm_valid load data and one-cycle completion pulse
//     o_dm_stall            load/store stall to hazard logic
//     o_mem_req/we/addr/wdata/wstrb  registered request to memory
//     i_mem_gnt/rvalid/rdata memory handshake and response
//     o_timeout             sticky timeout flag
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no transaction; arbitrate and latch winner when any request
//   ISSUE | o_mem_req high with stable payload, waiting for i_mem_gnt
//   WAIT  | granted, waiting for i_mem_rvalid
//   RESP  | one-cycle valid pulse to the owning requester

module mem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_if_req,
    input  logic [ADDR_WIDTH-1:0]     i_if_addr,
    output logic [DATA_WIDTH-1:0]     o_if_rdata,
    output logic                      o_if_valid,
    output logic                      o_if_stall,
    input  logic                      i_dm_req,
    input  logic                      i_dm_we,
    input  logic [ADDR_WIDTH-1:0]     i_dm_addr,
    input  logic [DATA_WIDTH-1:0]     i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0]   i_dm_wstrb,
    output logic [DATA_WIDTH-1:0]     o_dm_rdata,
    output logic                      o_dm_valid,
    output logic                      o_dm_stall,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_wstrb,
    input  logic                      i_mem_gnt,
    input  logic                      i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
    output logic                      o_timeout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    // Timer reloads to N-1 on entering ISSUE so that terminal count (0) is
    // reached in the N-th cycle spent in ISSUE+WAIT.
    localparam logic [TW-1:0] TMO_LOAD   = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit            TMO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state, next_state;
    logic            owner_if;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            any_req;
    logic            if_wins;
    logic            in_flight;
    logic            tmo_hit;
    logic            abort;
    logic            resp_ok;

    assign any_req   = i_if_req | i_dm_req;
    assign if_wins   = i_if_req & (~i_dm_req | (starve_cnt == STARVE_MAX));
    assign in_flight = (state == S_ISSUE) || (state == S_WAIT);
    assign resp_ok   = (state == S_WAIT) && i_mem_rvalid;
    assign tmo_hit   = TMO_EN && (tmo_cnt == '0);
    // A response arriving in the terminal cycle still counts as a completion.
    assign abort     = in_flight && tmo_hit && !resp_ok;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (any_req) next_state = S_ISSUE;
            S_ISSUE: begin
                if (abort)          next_state = S_RESP;
                else if (i_mem_gnt) next_state = S_WAIT;
            end
            S_WAIT:  if (resp_ok || abort) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_mem_req  = (state == S_ISSUE);
        o_if_valid = (state == S_RESP) &&  owner_if;
        o_dm_valid = (state == S_RESP) && !owner_if;
        o_if_stall = i_if_req & ~o_if_valid;
        o_dm_stall = i_dm_req & ~o_dm_valid;
    end

    // Winner, payload and response data
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            owner_if    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wstrb <= '0;
            o_if_rdata  <= '0;
            o_dm_rdata  <= '0;
            o_timeout   <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                owner_if <= if_wins;
                if (if_wins) begin
                    o_mem_we    <= 1'b0;
                    o_mem_addr  <= i_if_addr;
                    o_mem_wdata <= '0;
                    o_mem_wstrb <= '0;
                end else begin
                    o_mem_we    <= i_dm_we;
                    o_mem_addr  <= i_dm_addr;
                    o_mem_wdata <= i_dm_wdata;
                    o_mem_wstrb <= i_dm_we ? i_dm_wstrb : '0;
                end
            end
            if (resp_ok && !o_mem_we) begin
                if (owner_if) o_if_rdata <= i_mem_rdata;
                else          o_dm_rdata <= i_mem_rdata;
            end else if (abort) begin
                o_timeout <= 1'b1;
                if (owner_if) o_if_rdata <= '0;
                else          o_dm_rdata <= '0;
            end
        end
    end

    // Starvation counter: counts DM wins taken while IF is waiting
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            starve_cnt <= '0;
        end else if (!i_if_req) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE && any_req) begin
            if (if_wins)                      starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Transaction timeout: down-counter with terminal-count compare
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE) begin
            tmo_cnt <= TMO_LOAD;
        end else if (in_flight && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

endmodule
